// File: rtl/bsg_mux_segmented_pingpong.sv
// Two-slot ping-pong buffer feeding bsg_mux_segmented. Words are written
// alternately into slot 0 / slot 1, and sel_o points the downstream mux at the
// oldest buffered word so the mux output is always the FIFO head.
module bsg_mux_segmented_pingpong #(
  parameter int unsigned segments_p      = 1,
  parameter int unsigned segment_width_p = 16,
  // Enables the simulation check that yumi_i is only raised while v_o is high
  parameter bit          check_yumi_p    = 1'b1,
  localparam int unsigned width_lp       = segments_p * segment_width_p
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  input  logic [width_lp-1:0]   data_i,
  output logic                  ready_o,
  output logic [width_lp-1:0]   data0_o,
  output logic [width_lp-1:0]   data1_o,
  output logic [segments_p-1:0] sel_o,
  output logic                  v_o,
  input  logic                  yumi_i
);

  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic [width_lp-1:0] slot0_q;
  logic [width_lp-1:0] slot1_q;
  logic                enq;
  logic                deq;

  // Status is decoded from the registered count only, so ready_o has no
  // combinational dependence on yumi_i.
  assign ready_o = (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign sel_o   = {segments_p{rd_ptr_q}};
  assign data0_o = slot0_q;
  assign data1_o = slot1_q;

  // Dequeue is gated by v_o so a stray yumi_i on an empty buffer is harmless.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  // Occupancy next-state: simultaneous enqueue and dequeue leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, occupancy and slot state; reset discards every buffered word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      slot0_q  <= '0;
      slot1_q  <= '0;
    end else begin
      // A slot only changes when written, keeping the idle mux leg stable.
      if (enq) begin
        if (wr_ptr_q) begin
          slot1_q <= data_i;
        end else begin
          slot0_q <= data_i;
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  if (check_yumi_p) begin : g_yumi_check
    // Consumer must not acknowledge a word that is not there.
    assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
      else $error("bsg_mux_segmented_pingpong: yumi_i asserted while v_o low");
  end
`endif

endmodule

// File: tb/tb_bsg_mux_segmented_pingpong.sv
// Directed bench for the ping-pong buffer, configured as two 8-bit segments
// so sel_o replication is visible. Inputs change 1ns after a rising edge and
// outputs are sampled there too, well away from the next edge.
module tb_bsg_mux_segmented_pingpong;

  localparam int unsigned Segs = 2;
  localparam int unsigned SegW = 8;
  localparam int unsigned W    = Segs * SegW;

  logic            clk;
  logic            reset;
  logic            v_in;
  logic [W-1:0]    data_in;
  logic            ready;
  logic [W-1:0]    data0;
  logic [W-1:0]    data1;
  logic [Segs-1:0] sel;
  logic            v_out;
  logic            yumi;
  logic [W-1:0]    mux_out;

  int checks;
  int errors;

  // Illegal yumi is exercised deliberately, so the built-in check is disabled.
  bsg_mux_segmented_pingpong #(
    .segments_p     (Segs),
    .segment_width_p(SegW),
    .check_yumi_p   (1'b0)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .v_i    (v_in),
    .data_i (data_in),
    .ready_o(ready),
    .data0_o(data0),
    .data1_o(data1),
    .sel_o  (sel),
    .v_o    (v_out),
    .yumi_i (yumi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segmented mux: each segment picks its own leg by its sel bit.
  always_comb begin
    mux_out = '0;
    for (int s = 0; s < Segs; s++) begin
      mux_out[s*SegW +: SegW] = sel[s] ? data1[s*SegW +: SegW] : data0[s*SegW +: SegW];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    v_in = 1'b1;
    data_in = 16'h1234;
    step();
    v_in = 1'b0;
    chk("pre_reset_data0", data0, 16'h1234);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_v_o", {15'd0, v_out}, 16'd0);
    chk("reset_ready_o", {15'd0, ready}, 16'd1);
    chk("reset_sel_o", {14'd0, sel}, 16'd0);
    chk("reset_data0_o", data0, 16'h0000);
    chk("reset_data1_o", data1, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    v_in = 1'b1;
    data_in = 16'hA5A5;
    yumi = 1'b0;
    step();
    v_in = 1'b0;
    chk("single_v_o", {15'd0, v_out}, 16'd1);
    chk("single_sel_o", {14'd0, sel}, 16'd0);
    chk("single_data0_o", data0, 16'hA5A5);
    chk("single_ready_o", {15'd0, ready}, 16'd1);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("single_deq_v_o", {15'd0, v_out}, 16'd0);
    chk("single_deq_sel_o", {14'd0, sel}, 16'd3);
    chk("single_slot_kept", data0, 16'hA5A5);
  endtask

  task automatic test_fill();
    apply_reset();
    v_in = 1'b1;
    data_in = 16'h1111;
    step();
    data_in = 16'h2222;
    step();
    chk("fill_ready_o", {15'd0, ready}, 16'd0);
    chk("fill_v_o", {15'd0, v_out}, 16'd1);
    data_in = 16'h3333;
    step();
    v_in = 1'b0;
    chk("fill_drop_data0", data0, 16'h1111);
    chk("fill_drop_data1", data1, 16'h2222);
    chk("fill_head0", mux_out, 16'h1111);
    chk("fill_head0_sel", {14'd0, sel}, 16'd0);
    yumi = 1'b1;
    step();
    chk("fill_ready_after_deq", {15'd0, ready}, 16'd1);
    chk("fill_head1", mux_out, 16'h2222);
    chk("fill_head1_sel", {14'd0, sel}, 16'd3);
    step();
    yumi = 1'b0;
    chk("fill_empty_v_o", {15'd0, v_out}, 16'd0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_sel;
    apply_reset();
    v_in = 1'b1;
    data_in = 16'h0000;
    step();
    for (int i = 1; i < 8; i++) begin
      exp_sel = ((i - 1) % 2 == 1) ? 16'd3 : 16'd0;
      chk("stream_v_o", {15'd0, v_out}, 16'd1);
      chk("stream_sel_o", {14'd0, sel}, exp_sel);
      chk("stream_word", mux_out, 16'(i - 1));
      data_in = 16'(i);
      yumi = 1'b1;
      step();
    end
    v_in = 1'b0;
    yumi = 1'b0;
    chk("stream_last_word", mux_out, 16'h0007);
    chk("stream_last_sel", {14'd0, sel}, 16'd3);
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("stream_drain_v_o", {15'd0, v_out}, 16'd0);
  endtask

  task automatic test_illegal_yumi();
    apply_reset();
    yumi = 1'b1;
    step();
    yumi = 1'b0;
    chk("illegal_v_o", {15'd0, v_out}, 16'd0);
    chk("illegal_ready_o", {15'd0, ready}, 16'd1);
    chk("illegal_sel_o", {14'd0, sel}, 16'd0);
    v_in = 1'b1;
    data_in = 16'hCAFE;
    step();
    v_in = 1'b0;
    chk("illegal_then_data0", data0, 16'hCAFE);
    chk("illegal_then_sel", {14'd0, sel}, 16'd0);
    chk("illegal_then_v_o", {15'd0, v_out}, 16'd1);
    chk("illegal_then_ready", {15'd0, ready}, 16'd1);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    v_in = 1'b1;
    data_in = 16'h5A5A;
    step();
    data_in = 16'h6B6B;
    step();
    v_in = 1'b0;
    chk("midrst_full", {15'd0, ready}, 16'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_v_o", {15'd0, v_out}, 16'd0);
    chk("midrst_ready_o", {15'd0, ready}, 16'd1);
    @(negedge clk);
    reset = 1'b0;
    step();
    v_in = 1'b1;
    data_in = 16'hBEEF;
    step();
    v_in = 1'b0;
    chk("midrst_beef_data0", data0, 16'hBEEF);
    chk("midrst_beef_data1", data1, 16'h0000);
    chk("midrst_beef_sel", {14'd0, sel}, 16'd0);
    chk("midrst_beef_v_o", {15'd0, v_out}, 16'd1);
    chk("midrst_beef_ready", {15'd0, ready}, 16'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    v_in    = 1'b0;
    data_in = '0;
    yumi    = 1'b0;
    #12;
    reset = 1'b0;
    step();
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_illegal_yumi();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
